// File: rtl/sfu_issue_scheduler.sv
// rtl/sfu_issue_scheduler.sv - issue/writeback scheduler for the scalar functional units.
// Optional round-robin writeback arbitration: define SFU_WB_ROUND_ROBIN_EN.
module sfu_issue_scheduler #(
  parameter int NREGS  = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              issue_valid,
  input  logic [1:0]        issue_sfu,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic [4:0]        issue_rd,
  input  logic              issue_wen,
  output logic              issue_ready,
  output logic              mul_start,
  output logic              div_start,
  output logic              lsu_start,
  input  logic              mul_done,
  input  logic              div_done,
  input  logic              lsu_done,
  input  logic [WORD_W-1:0] mul_result,
  input  logic [WORD_W-1:0] div_result,
  input  logic [WORD_W-1:0] lsu_result,
  output logic              mul_ack,
  output logic              div_ack,
  output logic              lsu_ack,
  input  logic [WORD_W-1:0] arith_result,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  pending_mask
);

  // Unit slots are ordered by fixed priority so the lowest index wins.
  localparam int NU = 3;
  localparam logic [1:0] U_DIV = 2'd0;
  localparam logic [1:0] U_MUL = 2'd1;
  localparam logic [1:0] U_LSU = 2'd2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t [NU-1:0]       state_q, state_d;
  logic   [NU-1:0][4:0]  rd_q, rd_d;
  logic   [NU-1:0]       wen_q, wen_d;
  logic   [NREGS-1:0]    sb_q, sb_d;

  logic [NU-1:0]             done, req, gnt;
  logic [NU-1:0][WORD_W-1:0] res;
  logic [1:0]                gidx, iu;
  logic                      any_gnt, multi, raw, waw, str_haz, wbconf;

  function automatic logic [1:0] nxt_slot(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign done = {lsu_done, mul_done, div_done};
  assign res  = {lsu_result, mul_result, div_result};

  always_comb begin
    for (int k = 0; k < NU; k++) req[k] = done[k] & (state_q[k] == BUSY);
  end

`ifdef SFU_WB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d, cand;

  always_comb begin
    any_gnt = 1'b0;
    gidx    = 2'd0;
    cand    = nxt_slot(last_q);
    for (int k = 0; k < NU; k++) begin
      if (!any_gnt && req[cand]) begin
        any_gnt = 1'b1;
        gidx    = cand;
      end
      cand = nxt_slot(cand);
    end
    last_d = any_gnt ? gidx : last_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) last_q <= U_DIV;
    else       last_q <= last_d;
  end
`else
  always_comb begin
    any_gnt = 1'b0;
    gidx    = 2'd0;
    for (int k = 0; k < NU; k++) begin
      if (!any_gnt && req[k]) begin
        any_gnt = 1'b1;
        gidx    = 2'(k);
      end
    end
  end
`endif

  assign gnt = any_gnt ? (NU'(1) << gidx) : '0;

  always_comb begin
    case (issue_sfu)
      2'd1:    iu = U_MUL;
      2'd2:    iu = U_DIV;
      default: iu = U_LSU;
    endcase
  end

  // Register 0 never enters the scoreboard, so it can never match a hazard.
  assign multi   = issue_sfu != 2'd0;
  assign raw     = ((issue_rs1 != 5'd0) & sb_q[issue_rs1]) | ((issue_rs2 != 5'd0) & sb_q[issue_rs2]);
  assign waw     = issue_wen & (issue_rd != 5'd0) & sb_q[issue_rd];
  assign str_haz = multi & (state_q[iu] == BUSY);
  assign wbconf  = ~multi & issue_wen & any_gnt;

  assign issue_ready = issue_valid & ~raw & ~waw & ~str_haz & ~wbconf;
  assign mul_start   = issue_ready & (issue_sfu == 2'd1);
  assign div_start   = issue_ready & (issue_sfu == 2'd2);
  assign lsu_start   = issue_ready & (issue_sfu == 2'd3);

  assign div_ack = gnt[U_DIV];
  assign mul_ack = gnt[U_MUL];
  assign lsu_ack = gnt[U_LSU];

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if (any_gnt) begin
      rf_wen   = wen_q[gidx] & (rd_q[gidx] != 5'd0);
      rf_waddr = rd_q[gidx];
      rf_wdata = res[gidx];
    end else if (issue_ready && !multi && issue_wen) begin
      rf_wen   = issue_rd != 5'd0;
      rf_waddr = issue_rd;
      rf_wdata = arith_result;
    end
  end

  // Issue set is applied after the grant clear so a same-register set wins.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    sb_d    = sb_q;
    if (any_gnt) begin
      state_d[gidx] = IDLE;
      if (wen_q[gidx]) sb_d[rd_q[gidx]] = 1'b0;
    end
    if (issue_ready && multi) begin
      state_d[iu] = BUSY;
      rd_d[iu]    = issue_rd;
      wen_d[iu]   = issue_wen;
      if (issue_wen && issue_rd != 5'd0) sb_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < NU; k++) state_q[k] <= IDLE;
      rd_q  <= '0;
      wen_q <= '0;
      sb_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      sb_q    <= sb_d;
    end
  end

  assign pending_mask = sb_q;

endmodule

// File: tb/tb_sfu_issue_scheduler.sv
// tb/tb_sfu_issue_scheduler.sv - directed self-checking bench for sfu_issue_scheduler.
module tb_sfu_issue_scheduler;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        issue_valid, issue_wen;
  logic [1:0]  issue_sfu;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_ready, mul_start, div_start, lsu_start;
  logic        mul_done, div_done, lsu_done;
  logic [31:0] mul_result, div_result, lsu_result, arith_result;
  logic        mul_ack, div_ack, lsu_ack;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  int errors = 0;
  int checks = 0;
  logic [36:0] wb_q[$];
  logic [36:0] wb_exp;

  sfu_issue_scheduler #(.NREGS(32), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_sfu(issue_sfu),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_ready(issue_ready),
    .mul_start(mul_start), .div_start(div_start), .lsu_start(lsu_start),
    .mul_done(mul_done), .div_done(div_done), .lsu_done(lsu_done),
    .mul_result(mul_result), .div_result(div_result), .lsu_result(lsu_result),
    .mul_ack(mul_ack), .div_ack(div_ack), .lsu_ack(lsu_ack),
    .arith_result(arith_result),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the oldest expected writeback.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && rf_wen === 1'b1) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        wb_exp = wb_q.pop_front();
        chk("wb_addr", 64'(rf_waddr), 64'(wb_exp[36:32]));
        chk("wb_data", 64'(rf_wdata), 64'(wb_exp[31:0]));
      end
    end
  end

  task automatic smp(); @(negedge CLK); endtask
  task automatic adv(); @(posedge CLK); #1; endtask

  task automatic issue(input logic [1:0] sfu, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic wen);
    issue_valid = 1'b1; issue_sfu = sfu; issue_rd = rd;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_wen = wen;
  endtask

  initial begin
    nRST = 1'b0; issue_valid = 1'b0; issue_sfu = 2'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    issue_rd = 5'd0; issue_wen = 1'b0; mul_done = 1'b0; div_done = 1'b0; lsu_done = 1'b0;
    mul_result = 32'd0; div_result = 32'd0; lsu_result = 32'd0; arith_result = 32'd0;

    smp();
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd0);
    chk("rst_rf", {rf_wen, rf_waddr, rf_wdata}, 64'd0);
    chk("rst_strobes", {mul_start, div_start, lsu_start, mul_ack, div_ack, lsu_ack}, 64'd0);
    adv(); nRST = 1'b1;

    // RAW stall behind MUL x5
    issue(2'd1, 5'd5, 5'd1, 5'd2, 1'b1);
    smp(); chk("mul_accept", {issue_ready, mul_start}, 64'b11);
    adv(); issue(2'd0, 5'd6, 5'd5, 5'd0, 1'b1); arith_result = 32'h0000_0606;
    smp(); chk("raw_stall", 64'(issue_ready), 64'd0);
    chk("pend_x5", 64'(pending_mask), 64'h20);
    chk("mul_start_pulse", 64'(mul_start), 64'd0);
    adv(); mul_done = 1'b1; mul_result = 32'hAAAA_0005; wb_q.push_back({5'd5, 32'hAAAA_0005});
    smp(); chk("mul_ack_x5", 64'(mul_ack), 64'd1);
    chk("no_bypass", 64'(issue_ready), 64'd0);
    adv(); mul_done = 1'b0; wb_q.push_back({5'd6, 32'h0000_0606});
    smp(); chk("add_after_ack", 64'(issue_ready), 64'd1);
    chk("pend_x5_clr", 64'(pending_mask), 64'd0);
    adv(); issue_valid = 1'b0;

    // DIV structural hazard
    issue(2'd2, 5'd10, 5'd0, 5'd0, 1'b1);
    smp(); chk("div1_start", 64'(div_start), 64'd1);
    adv(); issue(2'd2, 5'd11, 5'd0, 5'd0, 1'b1);
    smp(); chk("div2_struct", {issue_ready, div_start}, 64'b00);
    adv(); div_done = 1'b1; div_result = 32'hD1D1_000A; wb_q.push_back({5'd10, 32'hD1D1_000A});
    smp(); chk("div1_ack", 64'(div_ack), 64'd1);
    chk("div2_still_blocked", 64'(issue_ready), 64'd0);
    adv(); div_done = 1'b0;
    smp(); chk("div2_start", {issue_ready, div_start}, 64'b11);
    adv(); issue_valid = 1'b0;
    smp(); chk("div2_one_pulse", 64'(div_start), 64'd0);
    chk("pend_x11", 64'(pending_mask), 64'h800);
    adv(); div_done = 1'b1; div_result = 32'hD2D2_000B; wb_q.push_back({5'd11, 32'hD2D2_000B});
    adv(); div_done = 1'b0;

    // simultaneous MUL/DIV completion
    issue(2'd1, 5'd7, 5'd0, 5'd0, 1'b1);
    adv(); issue(2'd2, 5'd8, 5'd0, 5'd0, 1'b1);
    adv(); issue_valid = 1'b0;
    mul_done = 1'b1; mul_result = 32'h7777_0007; div_done = 1'b1; div_result = 32'h8888_0008;
    wb_q.push_back({5'd8, 32'h8888_0008}); wb_q.push_back({5'd7, 32'h7777_0007});
    smp(); chk("pair_c1_acks", {div_ack, mul_ack}, 64'b10);
    chk("pair_c1_addr", 64'(rf_waddr), 64'd8);
    adv(); div_done = 1'b0;
    smp(); chk("pair_c2_acks", {div_ack, mul_ack}, 64'b01);
    chk("pair_c2_addr", 64'(rf_waddr), 64'd7);
    adv(); mul_done = 1'b0;
    smp(); chk("pair_pend_clr", 64'(pending_mask), 64'd0);

    // ARITH writeback conflict with LSU
    issue(2'd3, 5'd12, 5'd0, 5'd0, 1'b1);
    adv(); lsu_done = 1'b1; lsu_result = 32'hC0DE_000C; wb_q.push_back({5'd12, 32'hC0DE_000C});
    issue(2'd0, 5'd9, 5'd0, 5'd0, 1'b1); arith_result = 32'h0000_0909;
    smp(); chk("wbconf_stall", {issue_ready, lsu_ack}, 64'b01);
    adv(); lsu_done = 1'b0; wb_q.push_back({5'd9, 32'h0000_0909});
    smp(); chk("add_x9_issue", {issue_ready, rf_waddr}, {59'd0, 1'b1, 5'd9});
    adv(); issue_valid = 1'b0;

    // store (wen=0) and MUL to x0
    issue(2'd3, 5'd3, 5'd1, 5'd2, 1'b0);
    smp(); chk("store_pend", 64'(pending_mask), 64'd0);
    adv(); issue_valid = 1'b0; lsu_done = 1'b1; lsu_result = 32'h5555_5555;
    smp(); chk("store_ack", {lsu_ack, rf_wen}, 64'b10);
    adv(); lsu_done = 1'b0; issue(2'd3, 5'd0, 5'd0, 5'd0, 1'b0);
    smp(); chk("lsu_idle_again", 64'(issue_ready), 64'd1);
    adv(); issue_valid = 1'b0; lsu_done = 1'b1;
    adv(); lsu_done = 1'b0; issue(2'd1, 5'd0, 5'd0, 5'd0, 1'b1);
    adv(); issue_valid = 1'b0;
    smp(); chk("x0_not_pending", 64'(pending_mask), 64'd0);
    adv(); mul_done = 1'b1; mul_result = 32'hBAD0_BAD0;
    smp(); chk("x0_ack_nowrite", {mul_ack, rf_wen}, 64'b10);
    adv(); mul_done = 1'b0;

    // reset while MUL and DIV are busy
    issue(2'd1, 5'd13, 5'd0, 5'd0, 1'b1);
    adv(); issue(2'd2, 5'd14, 5'd0, 5'd0, 1'b1);
    adv(); issue_valid = 1'b0;
    smp(); chk("busy_pend", 64'(pending_mask), 64'h6000);
    adv(); nRST = 1'b0;
    smp(); chk("midrst_pend", 64'(pending_mask), 64'd0);
    chk("midrst_strobes", {mul_start, div_start, lsu_start, mul_ack, div_ack, lsu_ack}, 64'd0);
    adv(); nRST = 1'b1; mul_done = 1'b1; div_done = 1'b1;
    smp(); chk("stale_done_ignored", {mul_ack, div_ack, rf_wen}, 64'd0);
    adv(); mul_done = 1'b0; div_done = 1'b0; issue(2'd1, 5'd13, 5'd0, 5'd0, 1'b1);
    smp(); chk("post_rst_issue", {issue_ready, mul_start}, 64'b11);
    adv(); issue_valid = 1'b0;
    smp();
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfu_issue_scheduler.md
Name: sfu_issue_scheduler

Overview:
- Issue and writeback scheduler for the scalar functional units (arith, mult, div, lsu) selected by the decoder's sfu_type.
- Tracks one outstanding operation per multi-cycle unit and keeps a per-register pending scoreboard. Stalls issue on RAW, WAW or structural hazards.
- Arbitrates the single register-file write port among unit completions.
- Sits between decode/control and the execute stage's functional units.

Parameters:
- NREGS, 32, architectural register count; scoreboard width.
- WORD_W, 32, result data width.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- issue_valid  input  1  decoded instruction presented for issue
- issue_sfu  input  2  target unit: 0=ARITH, 1=MUL, 2=DIV, 3=LSU
- issue_rs1, issue_rs2, issue_rd  input  5 each  register indices
- issue_wen  input  1  instruction writes rd
- issue_ready  output  1  instruction accepted this cycle
- mul_start, div_start, lsu_start  output  1 each  one-cycle launch pulse to unit
- mul_done, div_done, lsu_done  input  1 each  unit result valid; held until acked
- mul_result, div_result, lsu_result  input  WORD_W each  unit results
- mul_ack, div_ack, lsu_ack  output  1 each  result consumed this cycle
- arith_result  input  WORD_W  single-cycle ALU result for the issuing instruction
- rf_wen  output  1  register-file write enable
- rf_waddr  output  5  write index
- rf_wdata  output  WORD_W  write data
- pending_mask  output  NREGS  scoreboard, bit i = register i awaiting writeback

Behaviour:
- Reset: all registers cleared immediately on nRST low.
  - busy_{mul,div,lsu}=0, per-unit rd_q=0, wen_q=0, scoreboard=0.
  - Combinational outputs are then 0: issue_ready, starts, acks, rf_wen, rf_waddr, rf_wdata, pending_mask.
- Per-unit state is a two-state machine:
  - IDLE -> BUSY on accepted issue; latch rd_q=issue_rd, wen_q=issue_wen.
  - BUSY -> IDLE in the cycle its ack is asserted.
- Hazard conditions (all combinational):
  - raw = scoreboard[rs1] | scoreboard[rs2].
  - waw = issue_wen & scoreboard[rd].
  - Register 0 is never pending and never matches.
  - struct = target unit BUSY, for MUL/DIV/LSU.
  - wbconf = ARITH issue with issue_wen while any done request is being granted this cycle.
- issue_ready = issue_valid & ~raw & ~waw & ~struct & ~wbconf.
- Starts: x_start = issue_ready & (issue_sfu==x); a pulse of exactly one cycle.
- No bypass: a register being written back this cycle still counts as pending for hazard checks. The dependent instruction issues the following cycle.
- Writeback arbitration, same cycle, combinational:
  - Requesters are x_done & busy_x. A done with busy_x=0 is ignored and never acked.
  - Fixed priority DIV > MUL > LSU; one grant per cycle.
  - Granted unit: x_ack=1; rf_wen=wen_q & (rd_q!=0); rf_waddr=rd_q; rf_wdata=x_result.
  - No multi-cycle grant and ARITH issue accepted with issue_wen: rf_wen=(rd!=0), rf_waddr=issue_rd, rf_wdata=arith_result.
  - Otherwise rf_wen=0, rf_waddr=0, rf_wdata=0.
- A unit with wen_q=0 (e.g. store) is still acked to free the unit; no RF write occurs.
- Scoreboard:
  - Set bit rd on an accepted MUL/DIV/LSU issue with issue_wen and rd!=0.
  - Clear bit rd_q on grant.
  - Same-register set and clear in one cycle: set wins.
- Same-unit ack and new issue in one cycle: struct still blocks, because BUSY is evaluated before the ack. The unit re-issues the next cycle.
- Losing requesters keep done high and their result stable; the scheduler holds their state with no loss.
- Mid-operation reset: all state discarded. Units are reset by the same nRST.

Optional Feature:
- Macro: SFU_WB_ROUND_ROBIN_EN.
- Defined: a 2-bit last-grant pointer (reset to DIV) rotates priority among DIV, MUL, LSU. The unit after the last granted one has highest priority. The pointer updates only on a grant.
- Undefined: fixed DIV > MUL > LSU priority; no pointer register.

Test Plan:
- MUL x5 issue, then ADD x6 with rs1=x5 -> ADD stalled (issue_ready=0) until the cycle after mul_ack; pending_mask bit5 set then cleared.
- DIV busy, second DIV issued -> stalled; after div_ack, second DIV issues next cycle with div_start=1 for one cycle.
- mul_done and div_done high in the same cycle (rd=x7, x8) -> cycle 1: div_ack, rf_waddr=8; cycle 2: mul_ack, rf_waddr=7. With SFU_WB_ROUND_ROBIN_EN, a following simultaneous pair alternates the winner.
- ARITH ADD x9 issued while lsu_done high -> ADD stalled one cycle; LSU write first, then ADD writes arith_result to x9.
- LSU store (wen=0) completes -> lsu_ack=1, rf_wen=0, unit IDLE. MUL to x0 -> no scoreboard bit, rf_wen=0 on ack.
- nRST asserted while MUL and DIV busy -> pending_mask=0, all acks and starts 0; a fresh issue after release is accepted immediately.
